sw_dev: RTL and testbench

- Memory-mapped slide-switch input device on the processor's shared address/data bus; the input-direction counterpart of the LED output device.
- Synchronises and debounces the board switches and latches a stable value into a data register.
- Raises a ready flag on every change, with overrun detection and an optional interrupt line.
- The CPU polls or takes an interrupt, then reads the data and control registers via ld/addrbus/databus.

---
 rtl/sw_dev_pkg.sv | 22 ++
 rtl/sw_debounce.sv | 50 +++++
 rtl/sw_dev.sv | 90 +++++++++
 tb/tb_sw_dev.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sw_dev_pkg.sv
// Shared definitions for the memory-mapped bus devices (switches, keys, timer).
// Holds the default register addresses, control-register bit positions and
// the common address-decode helper every device uses on the shared bus.
package sw_dev_pkg;

  localparam int BUS_W = 32;

  localparam logic [BUS_W-1:0] SDATAADDR_DEF = 32'hFFFF_F090;
  localparam logic [BUS_W-1:0] SCTRLADDR_DEF = 32'hFFFF_F094;

  localparam int CTRL_READY_BIT = 0;
  localparam int CTRL_OVR_BIT   = 1;
  localparam int CTRL_IE_BIT    = 8;

  // A device responds only when its strobe is high and the full address matches.
  function automatic logic bus_hit(input logic             strobe,
                                   input logic [BUS_W-1:0] addr,
                                   input logic [BUS_W-1:0] dev_addr);
    return strobe && (addr == dev_addr);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous input pins
//   stable     : last accepted (debounced) value
//   change     : high in the cycle a new value is accepted; stable updates
//                at the following edge
module sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q, cand_q, stable_q;
  logic [CW-1:0]    cnt_q;

  // The candidate has been seen unchanged long enough and differs from what
  // was last accepted.
  assign change = (s2_q == cand_q) && (cnt_q == CNT_MAX) && (cand_q != stable_q);
  assign stable = stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (change) stable_q <= cand_q;
    end
  end

endmodule

// File: rtl/sw_dev.sv
// Slide-switch input device on the shared CPU address/data bus.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   ld, sw     : CPU load / store strobes
//   addrbus    : CPU address
//   databus    : shared data bus, driven only during a matching load
//   SW         : raw switch pins
//   intr       : interrupt request (READY & IE)
// Registers: SDATA (read-only debounced switches), SCTRL {IE@8, OVR@1, READY@0}.
module sw_dev
  import sw_dev_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter int               SWBITS          = 10,
  parameter logic [DBITS-1:0] SDATAADDR       = SDATAADDR_DEF,
  parameter logic [DBITS-1:0] SCTRLADDR       = SCTRLADDR_DEF,
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              sw,
  input  logic [DBITS-1:0]  addrbus,
  inout  wire  [DBITS-1:0]  databus,
  input  logic [SWBITS-1:0] SW,
  output logic              intr
);

  logic [SWBITS-1:0] sdata;
  logic              change;
  logic              ready_q, ovr_q, ie_q;
  logic              ready_d, ovr_d, ie_d;
  logic              rd_data, rd_ctrl, wr_ctrl;
  logic [DBITS-1:0]  rdata;

  sw_debounce #(
    .WIDTH          (SWBITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (SW),
    .stable(sdata),
    .change(change)
  );

  assign rd_data = bus_hit(ld, addrbus, SDATAADDR);
  assign rd_ctrl = bus_hit(ld, addrbus, SCTRLADDR);
  assign wr_ctrl = bus_hit(sw, addrbus, SCTRLADDR);

  always_comb begin
    rdata = '0;
    if (rd_data) begin
      rdata[SWBITS-1:0] = sdata;
    end else if (rd_ctrl) begin
      rdata[CTRL_READY_BIT] = ready_q;
      rdata[CTRL_OVR_BIT]   = ovr_q;
      rdata[CTRL_IE_BIT]    = ie_q;
    end
  end

  assign databus = (rd_data || rd_ctrl) ? rdata : {DBITS{1'bz}};
  assign intr    = ready_q & ie_q;

  always_comb begin
    ie_d    = wr_ctrl ? databus[CTRL_IE_BIT] : ie_q;
    // Software can only clear OVR; a new overrun in the same cycle wins.
    ovr_d   = wr_ctrl ? (ovr_q & databus[CTRL_OVR_BIT]) : ovr_q;
    ready_d = ready_q;
    if (rd_data) ready_d = 1'b0;
    if (change) begin
      ready_d = 1'b1;
      // A simultaneous SDATA read consumed the previous value, so no overrun.
      if (ready_q && !rd_data) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
    end
  end

endmodule

// File: tb/tb_sw_dev.sv
module tb_sw_dev;

  localparam int          DBITS  = 32;
  localparam int          SWBITS = 10;
  localparam logic [31:0] SDATA  = 32'hFFFF_F090;
  localparam logic [31:0] SCTRL  = 32'hFFFF_F094;
  localparam logic [31:0] IDLE   = 32'hFFFF_FFFF;  // pulled-up, undriven bus

  logic              clk = 1'b0;
  logic              reset, ld, sw;
  logic [DBITS-1:0]  addrbus;
  logic [SWBITS-1:0] SW;
  logic              intr;
  logic              cpu_oe;
  logic [DBITS-1:0]  cpu_dout;
  wire  [DBITS-1:0]  databus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign databus = cpu_oe ? cpu_dout : {DBITS{1'bz}};

  for (genvar i = 0; i < DBITS; i++) begin : g_pu
    pullup (databus[i]);
  end

  sw_dev #(
    .DBITS          (DBITS),
    .SWBITS         (SWBITS),
    .SDATAADDR      (SDATA),
    .SCTRLADDR      (SCTRL),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .sw     (sw),
    .addrbus(addrbus),
    .databus(databus),
    .SW     (SW),
    .intr   (intr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Combinational look at a register; ld is dropped before the next edge.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addrbus = a;
    ld      = 1'b1;
    #1;
    d  = databus;
    ld = 1'b0;
    #1;
  endtask

  // Load held across a clock edge so its side effects take place.
  task automatic rd_consume(input logic [31:0] a, output logic [31:0] d);
    addrbus = a;
    ld      = 1'b1;
    #1;
    d = databus;
    cyc();
    ld = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addrbus  = a;
    cpu_dout = v;
    cpu_oe   = 1'b1;
    sw       = 1'b1;
    cyc();
    sw     = 1'b0;
    cpu_oe = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    reset = 1'b1; ld = 1'b0; sw = 1'b0; addrbus = '0;
    cpu_oe = 1'b0; cpu_dout = '0; SW = 10'h3FF;
    cyc(2);
    reset = 1'b0;

    // Reset state and bus release
    peek(SDATA, d);  check("rst_sdata", d, 32'h0);
    peek(SCTRL, d);  check("rst_sctrl", d, 32'h0);
    check("rst_intr", {31'b0, intr}, 32'h0);
    #1 check("idle_bus", databus, IDLE);
    peek(32'hFFFF_F098, d);  check("other_addr_bus", d, IDLE);

    // 3FF present at reset release lands on the 7th edge
    cyc(6);
    peek(SDATA, d);  check("lat_edge6", d, 32'h0);
    cyc();
    peek(SDATA, d);  check("lat_edge7", d, 32'h3FF);
    peek(SCTRL, d);  check("lat_ready", d, 32'h1);
    rd_consume(SDATA, d);
    peek(SCTRL, d);  check("lat_ready_clr", d, 32'h0);

    // Return to 0, then clean change to 155
    SW = 10'h000;
    cyc(10);
    rd_consume(SDATA, d);  check("zero_read", d, 32'h0);
    SW = 10'h155;
    cyc(6);
    peek(SDATA, d);  check("155_edge6", d, 32'h0);
    cyc();
    peek(SDATA, d);  check("155_edge7", d, 32'h155);
    peek(SCTRL, d);  check("155_ready", d, 32'h1);
    rd_consume(SDATA, d);  check("155_read", d, 32'h155);
    peek(SCTRL, d);  check("155_ready_clr", d, 32'h0);

    // Glitch shorter than the debounce window is rejected
    SW = 10'h000;
    cyc(10);
    rd_consume(SDATA, d);
    SW = 10'h001;
    cyc(3);
    SW = 10'h000;
    cyc(10);
    peek(SDATA, d);  check("glitch_sdata", d, 32'h0);
    peek(SCTRL, d);  check("glitch_sctrl", d, 32'h0);

    // Two unread changes raise OVR; writing 1 keeps it, writing 0 clears it
    SW = 10'h001;
    cyc(10);
    SW = 10'h002;
    cyc(10);
    peek(SCTRL, d);  check("ovr_set", d, 32'h3);
    wr(SCTRL, 32'h2);
    peek(SCTRL, d);  check("ovr_wr1_keeps", d, 32'h3);
    wr(SCTRL, 32'h0);
    peek(SCTRL, d);  check("ovr_clear", d, 32'h1);
    wr(SDATA, 32'h3FF);
    peek(SDATA, d);  check("sdata_wr_ignored", d, 32'h2);
    rd_consume(SDATA, d);  check("ovr_read", d, 32'h2);
    wr(SCTRL, 32'h2);
    peek(SCTRL, d);  check("ovr_wr1_no_set", d, 32'h0);

    // Interrupt follows READY when enabled
    wr(SCTRL, 32'h100);
    peek(SCTRL, d);  check("ie_set", d, 32'h100);
    SW = 10'h003;
    cyc(6);
    check("intr_before", {31'b0, intr}, 32'h0);
    cyc();
    check("intr_rise", {31'b0, intr}, 32'h1);
    peek(SCTRL, d);  check("intr_sctrl", d, 32'h101);
    rd_consume(SDATA, d);  check("intr_read", d, 32'h3);
    check("intr_drop", {31'b0, intr}, 32'h0);

    // SDATA read in the same cycle as a change event
    SW = 10'h004;
    cyc(6);
    rd_consume(SDATA, d);  check("race_old", d, 32'h3);
    peek(SCTRL, d);  check("race_sctrl", d, 32'h101);
    rd_consume(SDATA, d);  check("race_new", d, 32'h4);
    peek(SCTRL, d);  check("race_after", d, 32'h100);

    // Reset during a debounce in progress
    SW = 10'h005;
    cyc(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    peek(SDATA, d);  check("rst2_sdata", d, 32'h0);
    peek(SCTRL, d);  check("rst2_sctrl", d, 32'h0);
    check("rst2_intr", {31'b0, intr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
